gic_master: RTL and testbench
=============================

GIC_MASTER -- requirements
Module: gic_master

Interface
REQ-001 SHALL have parameter IDLE, 4'b1111, nibble driven on gic_dat_o when no frame is being sent.
REQ-002 SHALL have parameter TIMEOUT, 1024, maximum cycles in WAIT before the bus cycle terminates with error.
REQ-003 SHALL have port wbs_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port wbs_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have Wishbone slave inputs: wbs_adr_i in 32, wbs_dat_i in 32, wbs_sel_i in 4, wbs_we_i in 1, wbs_stb_i in 1, wbs_cyc_i in 1, wbs_cti_i in 3 (ignored), wbs_bte_i in 2 (ignored).
REQ-006 SHALL have Wishbone slave outputs: wbs_dat_o out 32 read data; wbs_ack_o, wbs_err_o, wbs_rty_o out 1 each, cycle terminations.
REQ-007 SHALL have port gic_dat_i  in  4  nibble link from the remote GIC slave.
REQ-008 SHALL have port gic_dat_o  out  4  nibble link to the remote GIC slave; registered.

Function
REQ-009 SHALL accept a request when wbs_stb_i & wbs_cyc_i are high in IDLE; adr/dat/sel/we are latched that cycle and the Wishbone inputs are then ignored until termination.
REQ-010 SHALL use states IDLE, INIT, CMD, SEL, ADR, DAT, CKSUM, WAIT, RESP, RDAT, RCKSUM, TERM; one link nibble per cycle.
REQ-011 SHALL send the request frame on consecutive cycles: 4'b1010, cmd nibble {3'b000, we}, sel, 8 address nibbles MSB first, 8 data nibbles MSB first (writes only), checksum; gic_dat_o = IDLE at all other times.
REQ-012 SHALL compute the request checksum as XOR of sel, all address nibbles and all data nibbles, with the last (LSB) nibble of each 8-nibble group additionally XORed with 4'b1100.
REQ-013 SHALL, in WAIT, count cycles and move to RESP on the cycle after gic_dat_i == 4'b0101 is sampled.
REQ-014 SHALL sample the response nibble in RESP: 4'b0001 ack, 4'b0010 err, 4'b0100 rty; any other value SHALL be treated as err.
REQ-015 SHALL, for writes, go RESP -> TERM; for reads, RESP -> RDAT (8 nibbles MSB first into wbs_dat_o) -> RCKSUM, independent of the response code.
REQ-016 SHALL compute the response checksum as XOR of the 8 read nibbles, the last XORed with 4'b1100; a mismatch with the nibble received in RCKSUM SHALL override the response code with err.
REQ-017 SHALL, in TERM, pulse exactly one of ack/err/rty for one cycle and return to IDLE; a new request is not accepted in TERM.
REQ-018 SHALL terminate with a single-cycle wbs_err_o pulse and return to IDLE when the WAIT counter reaches TIMEOUT with no 4'b0101.
REQ-019 SHALL, if wbs_cyc_i drops mid-transaction, complete the link frame exchange but suppress the termination pulse.
REQ-020 SHALL hold wbs_dat_o stable from TERM until the next read's RDAT.

Reset
REQ-021 SHALL on wbs_rst_i enter IDLE, set gic_dat_o = IDLE, wbs_dat_o = 0, ack/err/rty = 0, counters and checksum to 0.
REQ-022 SHALL abort any frame in progress on reset without emitting a termination; the next cycle after reset drives IDLE.

Structure
REQ-023 SHALL place the initiate nibbles (4'b1010, 4'b0101), idle default, response codes, cmd bit and checksum mask 4'b1100 in a shared gic package used by both link endpoints.
REQ-024 SHALL implement the nibble checksum accumulator as sub-module gic_cksum (clear, enable, nibble, last-flag inputs; 4-bit output), shared with the slave endpoint.

Verification
REQ-025 Write sel=4'hF adr=0 dat=0 -> link shows 1010,0001,1111, 16x0000, checksum 1111; slave replies 0101,0001 -> one ack pulse.
REQ-026 Read adr=0x00000010; slave replies 0101,0001, nibbles 1..8, checksum 0100 -> wbs_dat_o=0x12345678 with ack.
REQ-027 Same read with checksum 0000 -> err pulse, no ack.
REQ-028 Write, slave replies 0101,0100 -> rty pulse; response 0011 -> err pulse.
REQ-029 Request with no 0101 for 1024 cycles -> err pulse, FSM back in IDLE, gic_dat_o=1111.
REQ-030 Reset asserted mid-ADR -> gic_dat_o=1111 next cycle, no termination pulse, next request runs normally.

Source files
------------

// File: rtl/gic_pkg.sv
// Shared GIC nibble-link definitions: framing nibbles, response codes, checksum
// mask and helpers used by both the master and slave link endpoints.
package gic_pkg;

  localparam logic [3:0] GIC_INIT_REQ   = 4'b1010;
  localparam logic [3:0] GIC_INIT_RSP   = 4'b0101;
  localparam logic [3:0] GIC_IDLE_NIB   = 4'b1111;
  localparam logic [3:0] GIC_RSP_ACK    = 4'b0001;
  localparam logic [3:0] GIC_RSP_ERR    = 4'b0010;
  localparam logic [3:0] GIC_RSP_RTY    = 4'b0100;
  localparam logic [3:0] GIC_CMD_WR     = 4'b0001;
  localparam logic [3:0] GIC_CKSUM_MASK = 4'b1100;

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_CMD, ST_SEL, ST_ADR, ST_DAT,
    ST_CKSUM, ST_WAIT, ST_RESP, ST_RDAT, ST_RCKSUM, ST_TERM
  } gic_state_e;

  typedef enum logic [1:0] {TRM_ACK, TRM_ERR, TRM_RTY} gic_term_e;

  // Unknown response codes are folded into an error termination.
  function automatic gic_term_e gic_decode_rsp(input logic [3:0] nib);
    gic_term_e res;
    case (nib)
      GIC_RSP_ACK: res = TRM_ACK;
      GIC_RSP_RTY: res = TRM_RTY;
      default:     res = TRM_ERR;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] gic_word_nib(input logic [31:0] w, input logic [2:0] idx);
    logic [31:0] sh;
    sh = w >> {~idx, 2'b00};
    return sh[3:0];
  endfunction

endpackage

// File: rtl/gic_cksum.sv
// Nibble XOR checksum accumulator; the last nibble of a word group is folded
// with the checksum mask so word boundaries affect the result.
module gic_cksum
  import gic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] nib_i,
  input  logic       last_i,
  output logic [3:0] cksum_o
);

  logic [3:0] acc_q, acc_d, base_s;

  always_comb begin
    base_s = clr_i ? 4'b0000 : acc_q;
    acc_d  = base_s;
    if (en_i) begin
      acc_d = base_s ^ nib_i ^ (last_i ? GIC_CKSUM_MASK : 4'b0000);
    end else begin
      acc_d = base_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= 4'b0000;
    else       acc_q <= acc_d;
  end

  assign cksum_o = acc_q;

endmodule

// File: rtl/gic_master.sv
// Wishbone slave to GIC nibble-link master: serialises one bus cycle into a
// request frame, waits for the remote response and terminates the bus cycle.
module gic_master
  import gic_pkg::*;
#(
  parameter logic [3:0] IDLE    = GIC_IDLE_NIB,
  parameter int         TIMEOUT = 1024
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  input  logic [3:0]  gic_dat_i,
  output logic [3:0]  gic_dat_o
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  gic_state_e     state_q, state_d;
  gic_term_e      code_q, code_d, fin_s;
  logic [2:0]     cnt_q, cnt_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [31:0]    adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]     sel_q, sel_d, gic_q, gic_d;
  logic           we_q, we_d, abort_q, abort_d;
  logic           ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic           to_term_s, ck_clr_s, ck_en_s, ck_last_s;
  logic [3:0]     ck_nib_s, ck_val_s;
  logic           unused_s;

  assign unused_s = ^{wbs_cti_i, wbs_bte_i};

  gic_cksum u_cksum (
    .clk_i   (wbs_clk_i),
    .rst_i   (wbs_rst_i),
    .clr_i   (ck_clr_s),
    .en_i    (ck_en_s),
    .nib_i   (ck_nib_s),
    .last_i  (ck_last_s),
    .cksum_o (ck_val_s)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    gic_d     = IDLE;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    to_term_s = 1'b0;
    fin_s     = code_q;
    ck_clr_s  = 1'b0;
    ck_en_s   = 1'b0;
    // A dropped cyc only silences the termination; the link exchange runs on.
    abort_d   = abort_q | ((state_q != ST_IDLE) & ~wbs_cyc_i);
    case (state_q)
      ST_IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          sel_d   = wbs_sel_i;
          we_d    = wbs_we_i;
          abort_d = 1'b0;
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        gic_d    = GIC_INIT_REQ;
        ck_clr_s = 1'b1;
        state_d  = ST_CMD;
      end
      ST_CMD: begin
        gic_d   = GIC_CMD_WR & {4{we_q}};
        state_d = ST_SEL;
      end
      ST_SEL: begin
        gic_d   = sel_q;
        ck_en_s = 1'b1;
        cnt_d   = 3'd0;
        state_d = ST_ADR;
      end
      ST_ADR: begin
        gic_d   = gic_word_nib(adr_q, cnt_q);
        ck_en_s = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = we_q ? ST_DAT : ST_CKSUM;
        else               state_d = ST_ADR;
      end
      ST_DAT: begin
        gic_d   = gic_word_nib(wdat_q, cnt_q);
        ck_en_s = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_CKSUM;
        else               state_d = ST_DAT;
      end
      ST_CKSUM: begin
        gic_d   = ck_val_s;
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ck_clr_s = 1'b1;
        if (gic_dat_i == GIC_INIT_RSP) begin
          state_d = ST_RESP;
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          to_term_s = 1'b1;
          fin_s     = TRM_ERR;
          state_d   = ST_TERM;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_RESP: begin
        code_d = gic_decode_rsp(gic_dat_i);
        cnt_d  = 3'd0;
        if (we_q) begin
          to_term_s = 1'b1;
          fin_s     = gic_decode_rsp(gic_dat_i);
          state_d   = ST_TERM;
        end else begin
          state_d = ST_RDAT;
        end
      end
      ST_RDAT: begin
        rdat_d  = {rdat_q[27:0], gic_dat_i};
        ck_en_s = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_RCKSUM;
        else               state_d = ST_RDAT;
      end
      ST_RCKSUM: begin
        to_term_s = 1'b1;
        fin_s     = (gic_dat_i != ck_val_s) ? TRM_ERR : code_q;
        state_d   = ST_TERM;
      end
      ST_TERM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ck_nib_s  = (state_q == ST_RDAT) ? gic_dat_i : gic_d;
    ck_last_s = ((state_q == ST_ADR) || (state_q == ST_DAT) || (state_q == ST_RDAT))
                && (cnt_q == 3'd7);
    if (to_term_s && !abort_d) begin
      case (fin_s)
        TRM_ACK: ack_d = 1'b1;
        TRM_RTY: rty_d = 1'b1;
        default: err_d = 1'b1;
      endcase
    end else begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      state_q <= ST_IDLE;
      code_q  <= TRM_ERR;
      cnt_q   <= 3'd0;
      wait_q  <= '0;
      adr_q   <= 32'd0;
      wdat_q  <= 32'd0;
      rdat_q  <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      gic_q   <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      gic_q   <= gic_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  assign gic_dat_o = gic_q;
  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_rty_o = rty_q;

endmodule

// File: tb/tb_gic_master.sv
// Scoreboard bench for gic_master: directed transactions push expected link
// nibbles and terminations; two monitors pop and compare what the DUT emits.
module tb_gic_master;

  logic        clk = 1'b0;
  logic        wbs_rst_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i, gic_dat_i, gic_dat_o;
  logic        wbs_we_i, wbs_stb_i, wbs_cyc_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;

  always #5 clk = ~clk;

  gic_master dut (
    .wbs_clk_i (clk),       .wbs_rst_i (wbs_rst_i),
    .wbs_adr_i (wbs_adr_i), .wbs_dat_i (wbs_dat_i), .wbs_sel_i (wbs_sel_i),
    .wbs_we_i  (wbs_we_i),  .wbs_stb_i (wbs_stb_i), .wbs_cyc_i (wbs_cyc_i),
    .wbs_cti_i (wbs_cti_i), .wbs_bte_i (wbs_bte_i), .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o), .wbs_err_o (wbs_err_o), .wbs_rty_o (wbs_rty_o),
    .gic_dat_i (gic_dat_i), .gic_dat_o (gic_dat_o)
  );

  typedef struct packed {
    logic [2:0]  kind;   // {ack, err, rty}
    logic        chk;
    logic [31:0] dat;
  } term_t;

  term_t      exp_term[$];
  logic [3:0] exp_nib[$];
  int         exp_len[$];
  int checks = 0, passes = 0, terms_seen = 0, frames_done = 0, coll = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  function automatic term_t mk(input logic [2:0] kind, input logic chk, input logic [31:0] dat);
    term_t t;
    t.kind = kind; t.chk = chk; t.dat = dat;
    return t;
  endfunction

  // Link monitor: a frame starts on the first non-idle nibble.
  always @(negedge clk) begin : link_mon
    logic [3:0] e;
    if (wbs_rst_i) begin
      coll = 0; exp_nib.delete(); exp_len.delete();
    end else if (coll == 0 && gic_dat_o != 4'hF) begin
      if (exp_len.size() == 0) check("unexpected_frame", {28'd0, gic_dat_o}, 32'h0000000F);
      else coll = exp_len.pop_front();
    end
    if (!wbs_rst_i && coll > 0) begin
      e = exp_nib.pop_front();
      check("link_nibble", {28'd0, gic_dat_o}, {28'd0, e});
      coll--;
      if (coll == 0) frames_done++;
    end
  end

  always @(negedge clk) begin : term_mon
    term_t t;
    if (!wbs_rst_i && (wbs_ack_o || wbs_err_o || wbs_rty_o)) begin
      terms_seen++;
      if (exp_term.size() == 0) begin
        check("unexpected_term", {29'd0, wbs_ack_o, wbs_err_o, wbs_rty_o}, 32'd0);
      end else begin
        t = exp_term.pop_front();
        check("term_kind", {29'd0, wbs_ack_o, wbs_err_o, wbs_rty_o}, {29'd0, t.kind});
        if (t.chk) check("read_data", wbs_dat_o, t.dat);
      end
    end
  end

  task automatic txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] ck);
    exp_nib.push_back(4'hA);
    exp_nib.push_back({3'b000, we});
    exp_nib.push_back(sel);
    for (int i = 7; i >= 0; i--) exp_nib.push_back(adr[4*i +: 4]);
    if (we) for (int i = 7; i >= 0; i--) exp_nib.push_back(dat[4*i +: 4]);
    exp_nib.push_back(ck);
    exp_len.push_back(we ? 20 : 12);
    @(negedge clk);
    wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_adr_i = ~adr; wbs_dat_i = ~dat; wbs_sel_i = ~sel;
  endtask

  task automatic send(input logic [3:0] n);
    @(negedge clk);
    gic_dat_i = n;
  endtask

  task automatic reply(input logic [3:0] code, input logic rd, input logic [31:0] d,
                       input logic [3:0] ck);
    send(4'h5);
    send(code);
    if (rd) begin
      for (int i = 7; i >= 0; i--) send(d[4*i +: 4]);
      send(ck);
    end
    send(4'hF);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 300) begin @(negedge clk); n++; end
    check("frame_complete", 32'(frames_done), 32'(target));
  endtask

  task automatic wait_terms(input int target, input int budget);
    int n = 0;
    while (terms_seen < target && n < budget) begin @(negedge clk); n++; end
    check("term_count", 32'(terms_seen), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    wbs_rst_i = 1'b1; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; wbs_sel_i = 4'd0;
    wbs_we_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_cti_i = 3'd0;
    wbs_bte_i = 2'd0; gic_dat_i = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_gic_dat_o", {28'd0, gic_dat_o}, 32'h0000000F);
    check("rst_wbs_dat_o", wbs_dat_o, 32'd0);
    check("rst_terms", {29'd0, wbs_ack_o, wbs_err_o, wbs_rty_o}, 32'd0);
    wbs_rst_i = 1'b0;

    // zero write, ack
    exp_term.push_back(mk(3'b100, 1'b0, 32'd0));
    txn(1'b1, 4'hF, 32'h0, 32'h0, 4'hF);
    wait_frames(1); reply(4'h1, 1'b0, 32'd0, 4'h0); wait_terms(1, 100);

    // read with good checksum
    exp_term.push_back(mk(3'b100, 1'b1, 32'h12345678));
    txn(1'b0, 4'hF, 32'h10, 32'h0, 4'h2);
    wait_frames(2); reply(4'h1, 1'b1, 32'h12345678, 4'h4); wait_terms(2, 100);

    // same read, bad checksum overrides ack
    exp_term.push_back(mk(3'b010, 1'b0, 32'd0));
    txn(1'b0, 4'hF, 32'h10, 32'h0, 4'h2);
    wait_frames(3); reply(4'h1, 1'b1, 32'h12345678, 4'h0); wait_terms(3, 100);

    // write, retry response
    exp_term.push_back(mk(3'b001, 1'b0, 32'd0));
    txn(1'b1, 4'h3, 32'hDEADBEEF, 32'h01234567, 4'h3);
    wait_frames(4); reply(4'h4, 1'b0, 32'd0, 4'h0); wait_terms(4, 100);

    // write, illegal response code
    exp_term.push_back(mk(3'b010, 1'b0, 32'd0));
    txn(1'b1, 4'h3, 32'hDEADBEEF, 32'h01234567, 4'h3);
    wait_frames(5); reply(4'h3, 1'b0, 32'd0, 4'h0); wait_terms(5, 100);

    // read with err code still collects data
    exp_term.push_back(mk(3'b010, 1'b1, 32'h9ABCDEF0));
    txn(1'b0, 4'hF, 32'h0, 32'h0, 4'h3);
    wait_frames(6); reply(4'h2, 1'b1, 32'h9ABCDEF0, 4'h4); wait_terms(6, 100);

    // timeout: no response at all
    exp_term.push_back(mk(3'b010, 1'b0, 32'd0));
    txn(1'b0, 4'hF, 32'h0, 32'h0, 4'h3);
    wait_frames(7); wait_terms(7, 1200);
    check("timeout_gic_idle", {28'd0, gic_dat_o}, 32'h0000000F);

    // cyc dropped mid-frame: exchange completes, no termination
    txn(1'b1, 4'hF, 32'h0, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    wbs_cyc_i = 1'b0;
    wait_frames(8); reply(4'h1, 1'b0, 32'd0, 4'h0);
    repeat (20) @(negedge clk);
    check("cyc_drop_no_term", 32'(terms_seen), 32'd7);
    wbs_cyc_i = 1'b1;

    // reset while address nibbles are going out
    txn(1'b1, 4'hF, 32'h0, 32'h0, 4'hF);
    n = 0;
    while (gic_dat_o != 4'hA && n < 50) begin @(negedge clk); n++; end
    check("frame_start_seen", {28'd0, gic_dat_o}, 32'h0000000A);
    repeat (2) @(negedge clk);
    wbs_rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_adr_gic", {28'd0, gic_dat_o}, 32'h0000000F);
    @(negedge clk);
    wbs_rst_i = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_term", 32'(terms_seen), 32'd7);
    check("rst_mid_gic_idle", {28'd0, gic_dat_o}, 32'h0000000F);

    // normal write afterwards
    exp_term.push_back(mk(3'b100, 1'b0, 32'd0));
    txn(1'b1, 4'hF, 32'h0, 32'h0, 4'hF);
    wait_frames(9); reply(4'h1, 1'b0, 32'd0, 4'h0); wait_terms(8, 100);

    check("term_queue_empty", 32'(exp_term.size()), 32'd0);
    check("link_queue_empty", 32'(exp_nib.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
